// File: rtl/definitions.sv
// Shared ALU definitions: opcode mnemonics plus the issue controller's
// state encoding, branch opcode and instruction field layout.
package definitions;

  typedef enum logic [3:0] {
    KADD = 4'h0,
    KSUB = 4'h1,
    KMUL = 4'h2,
    KDIV = 4'h3,
    KLOA = 4'h4,
    KSTR = 4'h5,
    KSHL = 4'h6,
    KSHR = 4'h7,
    KAND = 4'h8,
    kor  = 4'h9
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } issue_state_e;

  localparam logic [3:0] BR_CODE_DEF = 4'hF;

  localparam int INST_W = 9;
  localparam int OP_LSB = 5;
  localparam int OP_W   = 4;
  localparam int RD_LSB = 2;
  localparam int RB_LSB = 0;
  localparam int RB_W   = 2;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode decode: ALU opcode to drive, branch qualifier,
// write-back enable and divide detection.
module alu_issue_decode
  import definitions::*;
#(
  parameter logic [3:0] BR_CODE = BR_CODE_DEF
) (
  input  logic [3:0] op,
  output logic [3:0] alu_op,
  output logic       is_branch,
  output logic       wb_en,
  output logic       is_div
);

  always_comb begin
    alu_op    = op;
    is_branch = 1'b0;
    wb_en     = 1'b0;
    is_div    = 1'b0;
    // Branch wins over any mnemonic sharing its code; the ALU evaluates it as a load.
    if (op == BR_CODE) begin
      alu_op    = KLOA;
      is_branch = 1'b1;
    end else begin
      case (op)
        KADD, KSUB, KMUL, KLOA, KSHL, KSHR, KAND, kor: begin
          wb_en = 1'b1;
        end
        KDIV: begin
          wb_en  = 1'b1;
          is_div = 1'b1;
        end
        KSTR: begin
          wb_en = 1'b0;
        end
        default: begin
          wb_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: latch instruction, read operands, drive the
// combinational ALU, then pulse write-back / branch-taken for one cycle.
module alu_issue_ctrl
  import definitions::*;
#(
  parameter int         NREG    = 8,
  parameter logic [3:0] BR_CODE = BR_CODE_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      INST_VALID,
  input  logic [INST_W-1:0]         INST,
  output logic                      INST_READY,
  output logic [$clog2(NREG)-1:0]   RF_RADDR_A,
  output logic [$clog2(NREG)-1:0]   RF_RADDR_B,
  input  logic [7:0]                RF_RDATA_A,
  input  logic [7:0]                RF_RDATA_B,
  output logic [3:0]                ALU_OP,
  output logic [7:0]                ALU_INA,
  output logic [7:0]                ALU_INB,
  output logic                      ALU_SC_IN,
  output logic                      ALU_IS_BRANCH,
  input  logic [7:0]                ALU_OUT,
  input  logic                      ALU_SC_OUT,
  input  logic                      ALU_BRANCH,
  input  logic                      ALU_ZERO,
  output logic                      WB_EN,
  output logic [$clog2(NREG)-1:0]   WB_ADDR,
  output logic [7:0]                WB_DATA,
  output logic                      BR_TAKEN,
  output logic [7:0]                BR_TARGET,
  output logic                      ZERO_FLAG,
  output logic                      DIV_ERR
);

  localparam int RD_W = $clog2(NREG);

  issue_state_e      state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [7:0]        opa_q, opa_d, opb_q, opb_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              is_branch_q, is_branch_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              ready_q, ready_d;
  logic              wb_en_q, wb_en_d;
  logic [RD_W-1:0]   wb_addr_q, wb_addr_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic              br_taken_q, br_taken_d;
  logic [7:0]        br_target_q, br_target_d;
  logic              div_err_q, div_err_d;

  logic [3:0]        dec_alu_op;
  logic              dec_is_branch, dec_wb_en, dec_is_div;
  logic [RD_W-1:0]   rd_s;
  logic              div_zero_s;

  assign rd_s       = inst_q[RD_LSB +: RD_W];
  assign div_zero_s = dec_is_div && (opb_q == 8'h00);

  alu_issue_decode #(.BR_CODE(BR_CODE)) u_decode (
    .op        (inst_q[OP_LSB +: OP_W]),
    .alu_op    (dec_alu_op),
    .is_branch (dec_is_branch),
    .wb_en     (dec_wb_en),
    .is_div    (dec_is_div)
  );

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    alu_op_d    = alu_op_q;
    is_branch_d = is_branch_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ready_d     = ready_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    div_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (INST_VALID && ready_q) begin
          inst_d  = INST;
          ready_d = 1'b0;
          state_d = READ;
        end else begin
          ready_d = 1'b1;
        end
      end
      READ: begin
        opa_d       = RF_RDATA_A;
        opb_d       = RF_RDATA_B;
        alu_op_d    = dec_alu_op;
        is_branch_d = dec_is_branch;
        state_d     = EXEC;
      end
      // ALU outputs are captured straight into the result registers so the
      // carry flag is already current for an instruction accepted after WB.
      EXEC: begin
        alu_op_d    = KADD;
        is_branch_d = 1'b0;
        carry_d     = ALU_SC_OUT;
        zero_d      = ALU_ZERO;
        wb_en_d     = dec_wb_en;
        wb_addr_d   = rd_s;
        if (dec_wb_en) begin
          if (div_zero_s) begin
            wb_data_d = 8'hFF;
          end else begin
            wb_data_d = ALU_OUT;
          end
        end else begin
          wb_data_d = wb_data_q;
        end
        br_taken_d = dec_is_branch && ALU_BRANCH;
        if (dec_is_branch) begin
          br_target_d = opb_q;
        end else begin
          br_target_d = br_target_q;
        end
        div_err_d = div_zero_s;
        state_d   = WB;
      end
      WB: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      inst_q      <= '0;
      opa_q       <= 8'h00;
      opb_q       <= 8'h00;
      alu_op_q    <= KADD;
      is_branch_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ready_q     <= 1'b1;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= 8'h00;
      br_taken_q  <= 1'b0;
      br_target_q <= 8'h00;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      alu_op_q    <= alu_op_d;
      is_branch_q <= is_branch_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ready_q     <= ready_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      div_err_q   <= div_err_d;
    end
  end

  assign INST_READY    = ready_q;
  assign RF_RADDR_A    = rd_s;
  assign RF_RADDR_B    = {{(RD_W-RB_W){1'b0}}, inst_q[RB_LSB +: RB_W]};
  assign ALU_OP        = alu_op_q;
  assign ALU_INA       = opa_q;
  assign ALU_INB       = opb_q;
  assign ALU_SC_IN     = carry_q;
  assign ALU_IS_BRANCH = is_branch_q;
  assign WB_EN         = wb_en_q;
  assign WB_ADDR       = wb_addr_q;
  assign WB_DATA       = wb_data_q;
  assign BR_TAKEN      = br_taken_q;
  assign BR_TARGET     = br_target_q;
  assign ZERO_FLAG     = zero_q;
  assign DIV_ERR       = div_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: owns the register file and a behavioural ALU,
// predicts each instruction's outcome from operand values and opcode rules.
module tb_alu_issue_ctrl;
  import definitions::*;

  logic       CLK, RESET, INST_VALID, INST_READY;
  logic [8:0] INST;
  logic [2:0] RF_RADDR_A, RF_RADDR_B, WB_ADDR;
  logic [7:0] RF_RDATA_A, RF_RDATA_B, ALU_INA, ALU_INB, ALU_OUT, WB_DATA, BR_TARGET;
  logic [3:0] ALU_OP;
  logic       ALU_SC_IN, ALU_IS_BRANCH, ALU_SC_OUT, ALU_BRANCH, ALU_ZERO;
  logic       WB_EN, BR_TAKEN, ZERO_FLAG, DIV_ERR;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rf [8];
  logic        carry_m, zero_m;
  logic [7:0]  e_a, e_b, e_data;
  logic [3:0]  e_aluop;
  logic [2:0]  e_rd;
  logic [1:0]  e_rb;
  logic        e_scin, e_wb, e_br, e_taken, e_div;
  logic [10:0] alu_res;
  logic [8:0]  inst_arr [12];

  alu_issue_ctrl dut (
    .CLK(CLK), .RESET(RESET), .INST_VALID(INST_VALID), .INST(INST),
    .INST_READY(INST_READY), .RF_RADDR_A(RF_RADDR_A), .RF_RADDR_B(RF_RADDR_B),
    .RF_RDATA_A(RF_RDATA_A), .RF_RDATA_B(RF_RDATA_B), .ALU_OP(ALU_OP),
    .ALU_INA(ALU_INA), .ALU_INB(ALU_INB), .ALU_SC_IN(ALU_SC_IN),
    .ALU_IS_BRANCH(ALU_IS_BRANCH), .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
    .ALU_BRANCH(ALU_BRANCH), .ALU_ZERO(ALU_ZERO), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .ZERO_FLAG(ZERO_FLAG), .DIV_ERR(DIV_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment ALU: returns {result, carry_out, zero, branch}.
  function automatic logic [10:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic sc, input logic isbr);
    logic [8:0]  t;
    logic [15:0] m;
    logic [7:0]  o;
    logic        c;
    o = 8'h00;
    c = 1'b0;
    case (op)
      KADD: begin t = {1'b0, a} + {1'b0, b}; o = t[7:0]; c = t[8]; end
      KSUB: begin t = {1'b0, a} - {1'b0, b}; o = t[7:0]; c = t[8]; end
      KMUL: begin m = {8'h00, a} * {8'h00, b}; o = m[7:0]; c = |m[15:8]; end
      KDIV: o = (b == 8'h00) ? 8'hAA : a / b;
      KLOA: o = b;
      KSTR: o = a;
      KSHL: begin o = {a[6:0], sc}; c = a[7]; end
      KSHR: begin o = {sc, a[7:1]}; c = a[0]; end
      KAND: o = a & b;
      kor:  o = a | b;
      default: o = 8'h00;
    endcase
    return {o, c, (o == 8'h00), (isbr && (a != 8'h00))};
  endfunction

  assign RF_RDATA_A = rf[RF_RADDR_A];
  assign RF_RDATA_B = rf[RF_RADDR_B];
  assign alu_res    = alu_f(ALU_OP, ALU_INA, ALU_INB, ALU_SC_IN, ALU_IS_BRANCH);
  assign {ALU_OUT, ALU_SC_OUT, ALU_ZERO, ALU_BRANCH} = alu_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of one instruction from the controller's rules.
  task automatic predict(input logic [3:0] op, input logic [2:0] rd, input logic [1:0] rb);
    logic [10:0] r;
    e_rd    = rd;
    e_rb    = rb;
    e_a     = rf[rd];
    e_b     = rf[{1'b0, rb}];
    e_br    = (op == 4'hF);
    e_aluop = e_br ? 4'(KLOA) : op;
    e_scin  = carry_m;
    r       = alu_f(e_aluop, e_a, e_b, carry_m, e_br);
    e_taken = e_br && (e_a != 8'h00);
    e_wb    = !e_br && (op inside {KADD, KSUB, KMUL, KDIV, KLOA, KSHL, KSHR, KAND, kor});
    e_div   = (op == 4'(KDIV)) && (e_b == 8'h00);
    e_data  = e_div ? 8'hFF : r[10:3];
    carry_m = r[2];
    zero_m  = r[1];
  endtask

  task automatic commit();
    if (e_wb) rf[e_rd] = e_data;
  endtask

  task automatic run_inst(input logic [3:0] op, input logic [2:0] rd, input logic [1:0] rb);
    int n;
    n = 0;
    while (INST_READY !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", 32'(INST_READY), 32'd1);
    predict(op, rd, rb);
    INST_VALID = 1'b1;
    INST = {op, rd, rb};
    @(posedge CLK);
    #1;
    INST_VALID = 1'($urandom_range(0, 1));
    INST = 9'($urandom);
    @(negedge CLK);
    chk("read_ready", 32'(INST_READY), 32'd0);
    chk("raddr_a", 32'(RF_RADDR_A), 32'(e_rd));
    chk("raddr_b", 32'(RF_RADDR_B), 32'(e_rb));
    @(negedge CLK);
    chk("exec_op", 32'(ALU_OP), 32'(e_aluop));
    chk("exec_ina", 32'(ALU_INA), 32'(e_a));
    chk("exec_inb", 32'(ALU_INB), 32'(e_b));
    chk("exec_scin", 32'(ALU_SC_IN), 32'(e_scin));
    chk("exec_isbr", 32'(ALU_IS_BRANCH), 32'(e_br));
    chk("exec_wben", 32'(WB_EN), 32'd0);
    @(negedge CLK);
    INST_VALID = 1'b0;
    chk("wb_en", 32'(WB_EN), 32'(e_wb));
    if (e_wb) begin
      chk("wb_addr", 32'(WB_ADDR), 32'(e_rd));
      chk("wb_data", 32'(WB_DATA), 32'(e_data));
    end
    chk("br_taken", 32'(BR_TAKEN), 32'(e_taken));
    if (e_br) chk("br_target", 32'(BR_TARGET), 32'(e_b));
    chk("div_err", 32'(DIV_ERR), 32'(e_div));
    chk("wb_op_kadd", 32'(ALU_OP), 32'(KADD));
    @(negedge CLK);
    chk("post_ready", 32'(INST_READY), 32'd1);
    chk("post_wben", 32'(WB_EN), 32'd0);
    chk("post_brt", 32'(BR_TAKEN), 32'd0);
    chk("post_diverr", 32'(DIV_ERR), 32'd0);
    chk("zero_flag", 32'(ZERO_FLAG), 32'(zero_m));
    commit();
  endtask

  initial begin
    logic [3:0] hop;
    RESET = 1'b1;
    INST_VALID = 1'b0;
    INST = 9'h000;
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    carry_m = 1'b0;
    zero_m  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(INST_READY), 32'd1);
    chk("rst_wben", 32'(WB_EN), 32'd0);
    chk("rst_brt", 32'(BR_TAKEN), 32'd0);
    chk("rst_diverr", 32'(DIV_ERR), 32'd0);
    chk("rst_zero", 32'(ZERO_FLAG), 32'd0);
    chk("rst_carry", 32'(ALU_SC_IN), 32'd0);
    chk("rst_wbaddr", 32'(WB_ADDR), 32'd0);
    chk("rst_wbdata", 32'(WB_DATA), 32'd0);
    chk("rst_brtgt", 32'(BR_TARGET), 32'd0);
    chk("rst_aluop", 32'(ALU_OP), 32'(KADD));
    chk("rst_ina", 32'(ALU_INA), 32'd0);
    chk("rst_inb", 32'(ALU_INB), 32'd0);
    chk("rst_isbr", 32'(ALU_IS_BRANCH), 32'd0);
    RESET = 1'b0;

    // Directed cases
    rf[1] = 8'h7F; rf[2] = 8'h02;
    run_inst(KADD, 3'd1, 2'd2);
    rf[3] = 8'h05; rf[1] = 8'h05;
    run_inst(KSUB, 3'd3, 2'd1);
    rf[5] = 8'hFF; rf[1] = 8'h01;
    run_inst(KADD, 3'd5, 2'd1);
    rf[4] = 8'h03; rf[2] = 8'h40;
    run_inst(4'hF, 3'd4, 2'd2);
    rf[4] = 8'h00;
    run_inst(4'hF, 3'd4, 2'd2);
    rf[1] = 8'h10; rf[2] = 8'h00;
    run_inst(KDIV, 3'd1, 2'd2);
    rf[1] = 8'h10; rf[2] = 8'h04;
    run_inst(KDIV, 3'd1, 2'd2);
    run_inst(KSTR, 3'd6, 2'd3);
    run_inst(4'hC, 3'd2, 2'd1);

    // INST_VALID held for 12 cycles with INST changing every cycle
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) begin
        chk("hold_ready_hi", 32'(INST_READY), 32'd1);
        if (k > 0) chk("hold_zero", 32'(ZERO_FLAG), 32'(zero_m));
      end else begin
        chk("hold_ready_lo", 32'(INST_READY), 32'd0);
      end
      if (k % 4 == 3) begin
        chk("hold_wben", 32'(WB_EN), 32'(e_wb));
        if (e_wb) begin
          chk("hold_wbaddr", 32'(WB_ADDR), 32'(e_rd));
          chk("hold_wbdata", 32'(WB_DATA), 32'(e_data));
        end
        commit();
      end
      case ($urandom_range(0, 3))
        0: hop = KADD;
        1: hop = KLOA;
        2: hop = kor;
        default: hop = KAND;
      endcase
      if (k == 4) hop = KSTR;
      inst_arr[k] = {hop, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (k % 4 == 0) predict(inst_arr[k][8:5], inst_arr[k][4:2], inst_arr[k][1:0]);
      INST_VALID = 1'b1;
      INST = inst_arr[k];
      @(negedge CLK);
    end
    INST_VALID = 1'b0;
    chk("hold_end_ready", 32'(INST_READY), 32'd1);
    @(negedge CLK);
    chk("hold_no_extra", 32'(INST_READY), 32'd1);

    // Set carry and zero, then abort an instruction with reset during EXEC
    rf[0] = 8'h00;
    run_inst(KAND, 3'd6, 2'd0);
    rf[7] = 8'h80;
    run_inst(KSHL, 3'd7, 2'd0);
    INST_VALID = 1'b1;
    INST = {4'(KADD), 3'd2, 2'd3};
    @(posedge CLK);
    #1 INST_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_in_exec", 32'(ALU_OP), 32'(KADD));
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_wben", 32'(WB_EN), 32'd0);
    chk("abort_brt", 32'(BR_TAKEN), 32'd0);
    chk("abort_ready", 32'(INST_READY), 32'd1);
    chk("abort_carry", 32'(ALU_SC_IN), 32'd0);
    chk("abort_zero", 32'(ZERO_FLAG), 32'd0);
    @(negedge CLK);
    chk("abort_wben2", 32'(WB_EN), 32'd0);
    carry_m = 1'b0;
    zero_m  = 1'b0;
    rf[6] = 8'h40;
    run_inst(KSHR, 3'd6, 2'd0);

    // Randomized instruction stream
    for (int j = 0; j < 40; j++) begin
      logic [3:0] rop;
      logic [2:0] rrd;
      logic [1:0] rrb;
      rop = 4'($urandom_range(0, 15));
      rrd = 3'($urandom_range(0, 7));
      rrb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rf[{1'b0, rrb}] = 8'h00;
      run_inst(rop, rrd, rrb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits upstream of the combinational ALU and drives its operation interface. It accepts one 9-bit instruction per handshake, reads two operands from the register file, and presents opcode, operands, carry-in and branch qualifier to the ALU. It then captures the ALU result, zero flag, carry-out and branch outcome, and issues a register write-back and/or a branch-taken pulse.

## Interface
- `NREG`, default 8: register-file depth; the `rd` field is log2(NREG) bits wide.
- `BR_CODE`, default 4'hF: opcode field value that denotes a conditional branch.
- `CLK`, input, 1: clock; all state updates on its rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `INST_VALID`, input, 1: `INST` holds a valid instruction.
- `INST`, input, 9: fields are `op`=[8:5], `rd`=[4:2] (also source A), `rb`=[1:0] (source B, r0..r3).
- `INST_READY`, output, 1: the block can accept an instruction.
- `RF_RADDR_A`, `RF_RADDR_B`, output, 3 each: register-file read addresses (combinational-read RF).
- `RF_RDATA_A`, `RF_RDATA_B`, input, 8 each: register-file read data.
- `ALU_OP`, output, 4: ALU opcode (`op_mne` encoding).
- `ALU_INA`, `ALU_INB`, output, 8 each: ALU operands.
- `ALU_SC_IN`, output, 1: carry/shift-in, taken from the internal carry flag.
- `ALU_IS_BRANCH`, output, 1: branch qualifier to the ALU.
- `ALU_OUT`, input, 8; `ALU_SC_OUT`, `ALU_BRANCH`, `ALU_ZERO`, input, 1 each: ALU results.
- `WB_EN`, output, 1: one-cycle register write strobe.
- `WB_ADDR`, output, 3: write address.
- `WB_DATA`, output, 8: write data.
- `BR_TAKEN`, output, 1: one-cycle pulse when a branch resolves taken.
- `BR_TARGET`, output, 8: branch target, equal to the captured B operand.
- `ZERO_FLAG`, output, 1: registered `ALU_ZERO` from the last executed instruction.
- `DIV_ERR`, output, 1: one-cycle pulse on `KDIV` with B==0.

## Operation
- The FSM has four states: IDLE → READ → EXEC → WB → IDLE.
- IDLE:
  - `INST_READY`=1.
  - When `INST_VALID`&`INST_READY`, latch `INST` and go to READ.
- READ:
  - Drive `RF_RADDR_A`=`rd` and `RF_RADDR_B`={1'b0,`rb`}.
  - Register `RF_RDATA_A`/`RF_RDATA_B` into the operand registers.
  - Go to EXEC.
- EXEC:
  - Drive the ALU from registers: `ALU_OP`=`op`, `ALU_INA`/`ALU_INB`=operands, `ALU_SC_IN`=carry flag.
  - If `op`==`BR_CODE`: `ALU_OP`=`KLOA` and `ALU_IS_BRANCH`=1.
  - Capture `ALU_OUT`, `ALU_ZERO`, `ALU_SC_OUT` and `ALU_BRANCH` at the end of the cycle, then go to WB.
- WB:
  - Pulse `WB_EN` with `WB_ADDR`=`rd` and `WB_DATA`=captured result, except for branch and `KSTR`, which do not write back.
  - Branch: `BR_TAKEN`=captured `ALU_BRANCH`, `BR_TARGET`=B operand.
  - Update the carry flag from the captured `ALU_SC_OUT`; update `ZERO_FLAG`.
  - Go to IDLE.
- Divide by zero: `KDIV` with B==0 forces the write-back data to 8'hFF and pulses `DIV_ERR` in WB. The ALU's raw result is ignored.
- Outside EXEC: `ALU_IS_BRANCH`=0 and `ALU_OP`=`KADD` with operands held. The ALU is combinational, so this has no side effects.
- Opcodes outside `op_mne` that are not `BR_CODE` execute as no-ops: no WB, no branch. The ALU default returns 0.
- Arithmetic is 8-bit with wrap-around, as computed by the ALU. This block performs no arithmetic except the B==0 compare.

## Timing
- Reset: state=IDLE, `INST_READY`=1, and `WB_EN`, `BR_TAKEN`, `DIV_ERR`, `ZERO_FLAG` and the carry flag all 0. `WB_ADDR`, `WB_DATA`, `BR_TARGET`, operands and `ALU_OP`(`KADD`) are 0.
- `RESET` asserted in any state aborts the in-flight instruction. No `WB_EN` or `BR_TAKEN` is issued for it, and the block is in IDLE on the next cycle.
- Latency: accept at edge N; READ in N+1; EXEC in N+2; `WB_EN`/`BR_TAKEN` high during N+3; `INST_READY` high again in N+4.
- Throughput: one instruction per 4 cycles.
- `INST_READY` is low in READ, EXEC and WB. `INST_VALID` held during those states is not consumed, and `INST` may change freely.
- `INST_VALID` asserted on the same edge that reset deasserts is accepted only on the first cycle with `RESET`=0.
- Carry-flag forwarding: an instruction accepted in the cycle right after WB sees the carry updated by that WB.

## Structure
- The `op_mne` values (`KADD`…`kor`) come from the shared `definitions` package.
- Add to that package:
  - the FSM state enum (`IDLE`, `READ`, `EXEC`, `WB`);
  - `BR_CODE`;
  - instruction field-position constants.
- One sub-module: `alu_issue_decode`, combinational. It maps `op` to {`alu_op`, `is_branch`, `wb_en`, `is_div`}.

## Test plan
- Reset then `INST`={`KADD`,r1,r2} with r1=8'h7F, r2=8'h02 → `WB_EN` at N+3, `WB_ADDR`=1, `WB_DATA`=8'h81, `ZERO_FLAG`=0, `INST_READY` high at N+4.
- `KSUB` with r3=5, r1=5 → `WB_DATA`=0, `ZERO_FLAG`=1. Then `KADD` 8'hFF+8'h01 → `WB_DATA`=0 (wrap).
- Branch (`op`=4'hF, rd=r4=8'h03, rb=r2=8'h40) → `BR_TAKEN`=1, `BR_TARGET`=8'h40, `WB_EN`=0. Repeat with r4=0 → `BR_TAKEN`=0.
- `KDIV` r1=8'h10, r2=0 → `DIV_ERR` pulse, `WB_DATA`=8'hFF. With r2=4 → `WB_DATA`=8'h04, no `DIV_ERR`.
- `INST_VALID` held high for 12 cycles with a changing `INST` → exactly 3 instructions accepted, each the value present in its IDLE cycle. `KSTR` produces no `WB_EN`.
- `RESET` pulsed during EXEC → no `WB_EN`/`BR_TAKEN`, IDLE and `INST_READY`=1 the next cycle, carry and `ZERO_FLAG` cleared.
